fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction-fetch front end sitting directly upstream of the single-cycle Datapath; supplies the instruction word (IWord) and its PC (PCVal).
- Owns the sequential fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned words in a small FIFO, presented to the Datapath with valid/ready.
- Accepts branch/jump redirects from the Datapath's PC-select path and flushes on redirect.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
DEPTH, 4, FIFO entries; power of two, at least 2

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state
redirect_valid  input  1  Datapath requests fetch restart (taken branch/jump)
redirect_pc  input  32  restart address; bits [1:0] ignored, treated as 00
imem_req  output  1  read request to instruction memory, registered
imem_addr  output  32  word address of the request, registered, bits [1:0]=00
imem_ack  input  1  one-cycle pulse: imem_rdata valid; only legal while imem_req=1
imem_rdata  input  32  instruction word returned with imem_ack
instr_valid  output  1  FIFO head holds a valid instruction
instr_ready  input  1  Datapath consumes the head this cycle
instr_word  output  32  head instruction (IWord), show-ahead
instr_pc  output  32  PC of head instruction (PCVal)

Behaviour:
- Reset (async, any time, including with a request in flight):
  - fetch_pc=RESET_PC; FIFO empty (count=0, rd_ptr=wr_ptr=0).
  - imem_req=0, imem_addr=0, instr_valid=0, instr_word=0, instr_pc=0; state=IDLE.
  - An in-flight memory transaction is abandoned; memory must tolerate this.
- FSM states: IDLE, WAIT, DISCARD.
  - IDLE: if count<DEPTH and !redirect_valid, then at the next edge imem_req=1, imem_addr=fetch_pc, state=WAIT.
  - WAIT:
    - imem_req and imem_addr are held stable until imem_ack.
    - On imem_ack with no redirect: push {fetch_pc, imem_rdata}; fetch_pc+=4.
    - After that push, if the post-push count<DEPTH, immediately re-issue (imem_req stays 1, imem_addr=new fetch_pc, stay WAIT). Otherwise imem_req=0 and go to IDLE.
  - DISCARD:
    - imem_req is held until imem_ack; the returned data is dropped, never pushed.
    - On imem_ack, go to IDLE, which then issues fetch_pc (the redirect target).
- Ack may arrive in the same cycle req is first high (combinational ROM) or any number of cycles later.
- FIFO:
  - instr_valid = (count!=0); instr_word and instr_pc come from the head entry, combinationally from FIFO storage.
  - Pop occurs when instr_valid && instr_ready. Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH. Push never occurs at count==DEPTH, because issue requires a free slot and only one request is outstanding.
  - instr_ready with instr_valid=0 has no effect.
- Redirect (highest priority, evaluated each cycle):
  - FIFO is flushed (count=0, so instr_valid=0 from the next cycle); any same-cycle pop and push are ignored.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - In WAIT without same-cycle ack: go to DISCARD.
  - In WAIT with same-cycle ack: data dropped, imem_req=0, go to IDLE.
  - In DISCARD: update fetch_pc and remain in DISCARD.
  - In IDLE: the new address is issued in the following cycle.
- Arithmetic: fetch_pc+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0.
- Latency: with an immediate-ack memory and instr_ready=1, the first instr_valid is the 2nd cycle after reset deassert, and throughput is 1 instruction/cycle.

Test Plan:
- Reset release, immediate-ack ROM holding word k = 32'h0000_0013+k, instr_ready=1 → imem_addr 0,4,8,… on consecutive cycles; instr_valid from cycle 2; instr_pc/instr_word pairs (0,0x13),(4,0x14),(8,0x15).
- instr_ready=0, immediate-ack ROM → exactly DEPTH=4 pushes; imem_req drops with count=4 and head pc=0. Raising ready restarts fetch at 0x10 with no lost or duplicated pc.
- Memory with ack 3 cycles after req, redirect_valid pulse with redirect_pc=0x103 while in WAIT on addr 0x8 → ack for 0x8 discarded. Next request addr=0x100 and first delivered instr_pc=0x100.
- redirect_valid in the same cycle as imem_ack and a pop, with count=2 → FIFO empty next cycle, no push, next imem_addr=redirect_pc.
- RESET_PC=32'hFFFF_FFF8, instr_ready=1 → instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert reset mid-WAIT with count=3 → all outputs 0 immediately (asynchronous), then fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Handshake bundle between the fetch front end, instruction memory and the
// Datapath. The master side is the fetch queue itself.
interface fetch_queue_if;
  // redirect from the Datapath PC-select path
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  // instruction memory read channel
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  // instruction delivery to the Datapath
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_word;
  logic [31:0] instr_pc;

  modport master (
    input  redirect_valid, redirect_pc, imem_ack, imem_rdata, instr_ready,
    output imem_req, imem_addr, instr_valid, instr_word, instr_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_ack, imem_rdata, instr_ready,
    input  imem_req, imem_addr, instr_valid, instr_word, instr_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the sequential fetch PC, issues one
// outstanding word read at a time and buffers returned words in a show-ahead
// FIFO for the Datapath. A redirect flushes the FIFO and restarts fetch; a
// read already in flight when the redirect lands is drained and dropped.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic          clk,
  input  logic          reset,
  fetch_queue_if.master bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [31:0] START_PC = {RESET_PC[31:2], 2'b00};

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_queue: DEPTH must be a power of two and at least 2");
  end

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  state_t        state, state_nx;
  logic [31:0]   fetch_pc, fetch_pc_nx;
  logic          req_q, req_nx;
  logic [31:0]   addr_q, addr_nx;

  logic [CW-1:0] count, count_nx;
  logic [PW-1:0] rd_ptr, wr_ptr;
  entry_t        mem [DEPTH];

  logic          redirect, ack, push, pop;
  logic [31:0]   redirect_base, pc_inc;
  logic          unused_redirect_lsb;

  assign redirect            = bus.redirect_valid;
  assign ack                 = bus.imem_ack & req_q;
  assign redirect_base       = {bus.redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];
  assign pc_inc              = fetch_pc + 32'd4;

  // Redirect overrides both FIFO ports; data acked while discarding never lands.
  assign pop  = (count != '0) & bus.instr_ready & ~redirect;
  assign push = (state == WAIT) & ack & ~redirect;

  // Occupancy after this edge; the re-issue decision looks at it so a
  // same-cycle pop can keep the stream going at one word per cycle.
  always_comb begin
    count_nx = count;
    if (redirect) begin
      count_nx = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_nx = count + CW'(1);
        2'b01:   count_nx = count - CW'(1);
        default: count_nx = count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // FSM next-state: one request outstanding at most, drained before reissue
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (!redirect && count != FULL) state_nx = WAIT;
      end
      WAIT: begin
        if (ack) begin
          if (redirect || count_nx == FULL) state_nx = IDLE;
          else                              state_nx = WAIT;
        end else if (redirect) begin
          state_nx = DISCARD;
        end
      end
      DISCARD: begin
        if (ack) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs: next request/address and the next fetch PC
  always_comb begin
    req_nx      = req_q;
    addr_nx     = addr_q;
    fetch_pc_nx = fetch_pc;
    if (redirect)  fetch_pc_nx = redirect_base;
    else if (push) fetch_pc_nx = pc_inc;
    case (state)
      IDLE: begin
        if (state_nx == WAIT) begin
          req_nx  = 1'b1;
          addr_nx = fetch_pc;
        end
      end
      WAIT: begin
        if (ack) begin
          if (state_nx == WAIT) begin
            req_nx  = 1'b1;
            addr_nx = pc_inc;
          end else begin
            req_nx  = 1'b0;
          end
        end
      end
      DISCARD: begin
        if (ack) req_nx = 1'b0;
      end
      default: req_nx = 1'b0;
    endcase
  end

  // Registered memory request and the architectural fetch PC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q    <= 1'b0;
      addr_q   <= '0;
      fetch_pc <= START_PC;
    end else begin
      req_q    <= req_nx;
      addr_q   <= addr_nx;
      fetch_pc <= fetch_pc_nx;
    end
  end

  // FIFO storage and pointers; a redirect empties it in one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (redirect) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count <= count_nx;
      if (push) begin
        mem[wr_ptr] <= '{pc: fetch_pc, word: bus.imem_rdata};
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = (count != '0);
  assign bus.instr_pc    = mem[rd_ptr].pc;
  assign bus.instr_word  = mem[rd_ptr].word;

endmodule
